// File: rtl/fixed_32_pkg.sv
// Shared constants and state encoding for the Q16.16 packet accumulator.
package fixed_32_pkg;

    localparam int          FRACT_BITS = 16;
    localparam logic [31:0] Q_MAX      = 32'h7FFF_FFFF;
    localparam logic [31:0] Q_MIN      = 32'h8000_0000;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/fixed_32_sat.sv
// Combinational clamp of a wide signed accumulator value to signed 32 bits.
module fixed_32_sat
    import fixed_32_pkg::*;
#(
    parameter int IN_W = 40
) (
    input  logic [IN_W-1:0] din,
    output logic [31:0]     dout,
    output logic            clamped
);

    logic [IN_W-32:0] upper;

    // Value fits when every bit from 31 upward equals the sign bit.
    always_comb begin
        upper   = din[IN_W-1:31];
        dout    = din[31:0];
        clamped = 1'b0;
        if (!((&upper) || !(|upper))) begin
            dout    = din[IN_W-1] ? Q_MIN : Q_MAX;
            clamped = 1'b1;
        end
    end

endmodule

// File: rtl/fixed_32_accum.sv
// Packet accumulator for signed Q16.16 terms with guard bits, sticky
// saturation/overflow flags and a held result.
// Handshake: a term transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. out_valid,
// once high, stays high with stable result outputs until that transfer, and
// never depends combinationally on out_ready.
module fixed_32_accum
    import fixed_32_pkg::*;
#(
    parameter int GUARD_BITS = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      p_in,
    input  logic             ovf_in,
    input  logic             in_last,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      sum_out,
    output logic             sat_out,
    output logic             ovf_out,
    output logic [CNT_W-1:0] term_cnt
);

    localparam int              ACC_W   = 32 + GUARD_BITS;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               isat_q, isat_d;
    logic               iovf_q, iovf_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        sum_q, sum_d;
    logic               sat_out_q, sat_out_d;
    logic               ovf_out_q, ovf_out_d;
    logic [CNT_W-1:0]   term_cnt_q, term_cnt_d;

    logic [ACC_W:0]     wide_sum;
    logic               add_ovf;
    logic [ACC_W-1:0]   acc_add;
    logic [CNT_W-1:0]   cnt_inc;
    logic               accept;
    logic [31:0]        clamp_val;
    logic               clamp_flag;

    assign in_ready  = (state_q == ST_ACCUM) && !clr;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign sum_out   = sum_q;
    assign sat_out   = sat_out_q;
    assign ovf_out   = ovf_out_q;
    assign term_cnt  = term_cnt_q;

    // Saturating add of the sign-extended term; counter holds at all-ones.
    always_comb begin
        wide_sum = {acc_q[ACC_W-1], acc_q} + {{(GUARD_BITS+1){p_in[31]}}, p_in};
        add_ovf  = wide_sum[ACC_W] ^ wide_sum[ACC_W-1];
        acc_add  = wide_sum[ACC_W-1:0];
        if (add_ovf) begin
            acc_add = wide_sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    end

    // Result clamp sees the accumulator value including the current term.
    fixed_32_sat #(.IN_W(ACC_W)) u_sat (
        .din     (acc_add),
        .dout    (clamp_val),
        .clamped (clamp_flag)
    );

    // Next-state logic for the ACCUM/HOLD controller and all registers.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        isat_d      = isat_q;
        iovf_d      = iovf_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        sat_out_d   = sat_out_q;
        ovf_out_d   = ovf_out_q;
        term_cnt_d  = term_cnt_q;
        case (state_q)
            ST_ACCUM: begin
                if (clr) begin
                    acc_d  = '0;
                    cnt_d  = '0;
                    isat_d = 1'b0;
                    iovf_d = 1'b0;
                end else if (accept) begin
                    acc_d  = acc_add;
                    cnt_d  = cnt_inc;
                    isat_d = isat_q | add_ovf;
                    iovf_d = iovf_q | ovf_in;
                    if (in_last) begin
                        state_d     = ST_HOLD;
                        out_valid_d = 1'b1;
                        sum_d       = clamp_val;
                        sat_out_d   = clamp_flag | isat_q | add_ovf;
                        ovf_out_d   = iovf_q | ovf_in;
                        term_cnt_d  = cnt_inc;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d     = ST_ACCUM;
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    cnt_d       = '0;
                    isat_d      = 1'b0;
                    iovf_d      = 1'b0;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // State and result registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            isat_q      <= 1'b0;
            iovf_q      <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            sat_out_q   <= 1'b0;
            ovf_out_q   <= 1'b0;
            term_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            isat_q      <= isat_d;
            iovf_q      <= iovf_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            sat_out_q   <= sat_out_d;
            ovf_out_q   <= ovf_out_d;
            term_cnt_q  <= term_cnt_d;
        end
    end

endmodule

// File: tb/tb_fixed_32_accum.sv
// Bench for fixed_32_accum: arithmetic reference model, per-cycle compare,
// directed scenarios with literal expectations and randomized packets.
module tb_fixed_32_accum;

    localparam int     GUARD_BITS = 8;
    localparam int     CNT_W      = 16;
    localparam int     RES_W      = 32 + 1 + 1 + CNT_W;
    localparam longint ACC_HI     = (longint'(1) << (31 + GUARD_BITS)) - 1;
    localparam longint ACC_LO     = -(longint'(1) << (31 + GUARD_BITS));
    localparam longint Q_HI       = 64'sd2147483647;
    localparam longint Q_LO       = -64'sd2147483648;
    localparam int     CNT_MAX    = (1 << CNT_W) - 1;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      p_in = '0;
    logic             ovf_in = 1'b0;
    logic             in_last = 1'b0;
    logic             clr = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      sum_out;
    logic             sat_out;
    logic             ovf_out;
    logic [CNT_W-1:0] term_cnt;

    always #5 clk = ~clk;

    fixed_32_accum #(.GUARD_BITS(GUARD_BITS), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p_in      (p_in),
        .ovf_in    (ovf_in),
        .in_last   (in_last),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .sat_out   (sat_out),
        .ovf_out   (ovf_out),
        .term_cnt  (term_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: DUT did not respond within cycle budget (handshake seen 0, required 1)", name);
    endtask

    // ---------------- reference model ----------------
    bit               m_hold = 1'b0;
    longint           m_acc  = 0;
    int               m_cnt  = 0;
    bit               m_sat  = 1'b0;
    bit               m_ovf  = 1'b0;
    longint           m_s;
    bit               m_c;
    logic [RES_W-1:0] exp_q[$];
    logic [RES_W-1:0] m_drop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hold = 1'b0; m_acc = 0; m_cnt = 0; m_sat = 1'b0; m_ovf = 1'b0;
            exp_q.delete();
        end else if (!m_hold) begin
            if (clr) begin
                m_acc = 0; m_cnt = 0; m_sat = 1'b0; m_ovf = 1'b0;
            end else if (in_valid) begin
                m_acc = m_acc + longint'($signed(p_in));
                if (m_acc > ACC_HI) begin
                    m_acc = ACC_HI; m_sat = 1'b1;
                end else if (m_acc < ACC_LO) begin
                    m_acc = ACC_LO; m_sat = 1'b1;
                end
                if (m_cnt < CNT_MAX) m_cnt++;
                m_ovf = m_ovf | ovf_in;
                if (in_last) begin
                    m_s = m_acc; m_c = 1'b0;
                    if (m_s > Q_HI) begin m_s = Q_HI; m_c = 1'b1; end
                    if (m_s < Q_LO) begin m_s = Q_LO; m_c = 1'b1; end
                    exp_q.push_back({32'(m_s), m_sat | m_c, m_ovf, CNT_W'(m_cnt)});
                    m_hold = 1'b1;
                end
            end
        end else if (out_ready) begin
            m_drop = exp_q.pop_front();
            m_hold = 1'b0; m_acc = 0; m_cnt = 0; m_sat = 1'b0; m_ovf = 1'b0;
        end
    end

    // ---------------- scoreboard compare (every cycle) ----------------
    always @(negedge clk) begin
        check("in_ready", 64'(in_ready), 64'(!m_hold && !clr));
        check("out_valid", 64'(out_valid), 64'(m_hold));
        if (m_hold && exp_q.size() > 0)
            check("result", 64'({sum_out, sat_out, ovf_out, term_cnt}), 64'(exp_q[0]));
    end

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        in_valid = 1'b0; p_in = '0; ovf_in = 1'b0; in_last = 1'b0; clr = 1'b0;
    endtask

    task automatic send_term(input logic [31:0] p, input logic ovf, input logic last);
        int  n;
        bit  done;
        n = 0; done = 1'b0;
        in_valid = 1'b1; p_in = p; ovf_in = ovf; in_last = last;
        while (!done) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk); #1;
            n++;
            if (!done && n > 50) begin
                timeout_fail("send_term");
                done = 1'b1;
            end
        end
        in_valid = 1'b0; ovf_in = 1'b0; in_last = 1'b0;
    endtask

    task automatic clr_pulse(input logic with_valid);
        in_valid = with_valid; p_in = $urandom; in_last = 1'(($urandom_range(0, 1)));
        clr = 1'b1;
        @(posedge clk); #1;
        drive_idle();
    endtask

    // Called right after the last-term handshake; checks latency, literals, then consumes.
    task automatic collect(input string name, input bit lit, input logic [31:0] e_sum,
                           input logic e_sat, input logic e_ovf, input logic [CNT_W-1:0] e_cnt,
                           input int hold, input bit hold_clr);
        int n;
        n = 0;
        @(negedge clk);
        check({name, "_latency"}, 64'(out_valid), 64'd1);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) timeout_fail({name, "_wait"});
        if (lit) begin
            check({name, "_sum"}, 64'(sum_out), 64'(e_sum));
            check({name, "_sat"}, 64'(sat_out), 64'(e_sat));
            check({name, "_ovf"}, 64'(ovf_out), 64'(e_ovf));
            check({name, "_cnt"}, 64'(term_cnt), 64'(e_cnt));
        end
        clr = hold_clr;
        repeat (hold) @(negedge clk);
        clr = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, run incomplete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          nterms;
        int          mode;
        logic [31:0] v;
        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum_out), 64'd0);
        check("rst_sat", 64'(sat_out), 64'd0);
        check("rst_ovf", 64'(ovf_out), 64'd0);
        check("rst_cnt", 64'(term_cnt), 64'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Mixed-sign packet: 1.0 + 2.5 - 0.5 = 3.0
        send_term(32'h0001_0000, 1'b0, 1'b0);
        send_term(32'h0002_8000, 1'b0, 1'b0);
        send_term(32'hFFFF_8000, 1'b0, 1'b1);
        collect("s1", 1'b1, 32'h0003_0000, 1'b0, 1'b0, 16'd3, 2, 1'b0);

        // Positive clamp
        send_term(32'h7FFF_0000, 1'b0, 1'b0);
        send_term(32'h7FFF_0000, 1'b0, 1'b1);
        collect("s2", 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 16'd2, 0, 1'b0);

        // Negative clamp
        send_term(32'h8000_0000, 1'b0, 1'b0);
        send_term(32'hFFFF_0000, 1'b0, 1'b1);
        collect("s3", 1'b1, 32'h8000_0000, 1'b1, 1'b0, 16'd2, 0, 1'b0);

        // Upstream overflow flag is sticky and does not touch the sum
        send_term(32'h0001_0000, 1'b0, 1'b0);
        send_term(32'h0001_0000, 1'b1, 1'b0);
        send_term(32'h0001_0000, 1'b0, 1'b1);
        collect("s4", 1'b1, 32'h0003_0000, 1'b0, 1'b1, 16'd3, 1, 1'b1);

        // Back-pressure: result held 5 cycles while a new term waits
        send_term(32'h0005_0000, 1'b0, 1'b1);
        in_valid = 1'b1; p_in = 32'h0002_0000; in_last = 1'b1;
        @(negedge clk);
        check("s5_valid", 64'(out_valid), 64'd1);
        repeat (5) begin
            @(negedge clk);
            check("s5_hold_ready", 64'(in_ready), 64'd0);
            check("s5_hold_sum", 64'(sum_out), 64'h0005_0000);
            check("s5_hold_cnt", 64'(term_cnt), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("s5_ready_after", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        drive_idle();
        collect("s5b", 1'b1, 32'h0002_0000, 1'b0, 1'b0, 16'd1, 0, 1'b0);

        // Internal guard-bit saturation: drives the accumulator to its top, then back to -1
        for (int i = 0; i < 260; i++) send_term(32'h7FFF_FFFF, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) send_term(32'h8000_0000, 1'b0, 1'(i == 255));
        collect("s6", 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 16'd516, 0, 1'b0);

        // Reset mid-packet, then clr with a valid term, then a fresh packet
        send_term(32'h0004_0000, 1'b1, 1'b0);
        send_term(32'h0004_0000, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("s7_rst_valid", 64'(out_valid), 64'd0);
        check("s7_rst_cnt", 64'(term_cnt), 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        clr = 1'b1; in_valid = 1'b1; p_in = 32'h0007_0000; in_last = 1'b1;
        @(negedge clk);
        check("s7_clr_ready", 64'(in_ready), 64'd0);
        check("s7_clr_outs", 64'({out_valid, sum_out, sat_out, ovf_out, term_cnt}), 64'd0);
        @(posedge clk); #1;
        drive_idle();
        send_term(32'h0001_0000, 1'b0, 1'b1);
        collect("s7", 1'b1, 32'h0001_0000, 1'b0, 1'b0, 16'd1, 0, 1'b0);

        // Randomized packets, checked by the model each cycle
        for (int pk = 0; pk < 40; pk++) begin
            nterms = $urandom_range(1, 6);
            for (int t = 0; t < nterms; t++) begin
                if ($urandom_range(0, 9) == 0) clr_pulse(1'($urandom_range(0, 1)));
                mode = $urandom_range(0, 3);
                case (mode)
                    0: v = 32'($signed($urandom_range(0, 32'h0008_0000)) - 32'sh0004_0000);
                    1: v = $urandom;
                    2: v = {16'h7FFF, 16'($urandom)};
                    default: v = {16'h8000, 16'($urandom)};
                endcase
                send_term(v, 1'($urandom_range(0, 7) == 0), 1'(t == nterms - 1));
            end
            collect("rnd", 1'b0, 32'h0, 1'b0, 1'b0, '0, $urandom_range(0, 3),
                    1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
